// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port: the MIPS core has default
// priority, and an auxiliary master gets idle slots, anti-starvation slots and bounded bursts.
module dmem_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run,
  output logic          cpu_enable,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic          aux_lock,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_gnt,
  output logic [DW-1:0] aux_rdata,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned BEAT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(BURST_MAX);
  localparam logic              BURSTS_ON  = (BURST_MAX > 1);

  typedef enum logic [0:0] {
    CPU_OWN = 1'b0,
    AUX_OWN = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                cpu_req;
  logic                aux_win;

  // Winner selection; reset low suppresses any aux grant.
  always_comb begin
    cpu_req = run & (cpu_rd | cpu_wr);
    aux_win = 1'b0;
    unique case (state_q)
      CPU_OWN: aux_win = aux_req & (~cpu_req | (wait_q == WAIT_LIMIT));
      AUX_OWN: aux_win = aux_req;
      default: aux_win = 1'b0;
    endcase
    aux_win = aux_win & reset_n;
  end

  // Port mux: the CPU drives dmem whenever aux does not win.
  always_comb begin
    aux_gnt    = aux_win;
    cpu_enable = reset_n & run & ~(cpu_req & aux_win);
    mem_addr   = aux_win ? aux_addr  : cpu_addr;
    mem_wdata  = aux_win ? aux_wdata : cpu_wdata;
    mem_wr     = reset_n & (aux_win ? aux_we : (cpu_wr & cpu_enable));
    cpu_rdata  = mem_rdata;
    aux_rdata  = mem_rdata;
  end

  // Next-state: starvation counter and burst ownership.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;

    if (aux_req & ~aux_win) begin
      wait_d = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end

    unique case (state_q)
      CPU_OWN: begin
        if (aux_win & aux_lock & BURSTS_ON) begin
          state_d = AUX_OWN;
          beat_d  = BEAT_W'(1);
        end
      end
      AUX_OWN: begin
        if (~aux_req | ~aux_lock | ((beat_q + BEAT_W'(1)) == BEAT_LIMIT)) begin
          state_d = CPU_OWN;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + BEAT_W'(1);
        end
      end
      default: begin
        state_d = CPU_OWN;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CPU_OWN;
      wait_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
    end
  end

endmodule
